// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding and constants for the fetch/data memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_REQ  = 3'd1,
        ST_I_WAIT = 3'd2,
        ST_I_DROP = 3'd3,
        ST_D_REQ  = 3'd4,
        ST_D_WAIT = 3'd5
    } arb_state_t;

    // Access code presented on the bus for instruction fetches (word access)
    localparam logic [3:0] FETCH_OP = 4'b0010;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and shared-bus signals seen by the memory arbiter
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic [DATA_WIDTH-1:0] if_inst_o;
    logic                  if_valid_o;

    logic                  d_req_i;
    logic                  d_we_i;
    logic [3:0]            d_op_i;
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic [DATA_WIDTH-1:0] d_wdata_i;
    logic [DATA_WIDTH-1:0] d_rdata_o;
    logic                  d_valid_o;

    logic                  flush_i;
    logic                  stallreq_o;

    logic                  bus_req_o;
    logic                  bus_we_o;
    logic [3:0]            bus_op_o;
    logic [ADDR_WIDTH-1:0] bus_addr_o;
    logic [DATA_WIDTH-1:0] bus_wdata_o;
    logic                  bus_gnt_i;
    logic                  bus_rvalid_i;
    logic [DATA_WIDTH-1:0] bus_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i, d_req_i, d_we_i, d_op_i, d_addr_i, d_wdata_i,
               flush_i, bus_gnt_i, bus_rvalid_i, bus_rdata_i,
        output if_inst_o, if_valid_o, d_rdata_o, d_valid_o, stallreq_o,
               bus_req_o, bus_we_o, bus_op_o, bus_addr_o, bus_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i, d_req_i, d_we_i, d_op_i, d_addr_i, d_wdata_i,
               flush_i, bus_gnt_i, bus_rvalid_i, bus_rdata_i,
        input  if_inst_o, if_valid_o, d_rdata_o, d_valid_o, stallreq_o,
               bus_req_o, bus_we_o, bus_op_o, bus_addr_o, bus_wdata_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises instruction fetch and data accesses onto one memory bus
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mem_arbiter_if.slave arb
);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    logic                  r_last_d;
    logic                  r_bus_req;
    logic                  r_bus_we;
    logic [3:0]            r_bus_op;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [DATA_WIDTH-1:0] r_bus_wdata;
    logic [DATA_WIDTH-1:0] r_if_inst;
    logic                  r_if_valid;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic                  r_d_valid;

    logic w_d_cand;
    logic w_i_cand;
    logic w_sel_d;
    logic w_sel_i;
    logic w_bus_drop;
    logic w_i_done;
    logic w_d_done;

    // A requester completing this cycle still holds its old request; skip it once
    assign w_d_cand = arb.d_req_i  & ~r_d_valid;
    assign w_i_cand = arb.if_req_i & ~r_if_valid;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_sel_d      = 1'b0;
        w_sel_i      = 1'b0;
        w_bus_drop   = 1'b0;
        w_i_done     = 1'b0;
        w_d_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_d_cand && (!w_i_cand || !r_last_d)) begin
                    w_sel_d      = 1'b1;
                    w_next_state = ST_D_REQ;
                end else if (w_i_cand) begin
                    w_sel_i      = 1'b1;
                    w_next_state = ST_I_REQ;
                end
            end
            ST_I_REQ: begin
                if (arb.flush_i) begin
                    w_bus_drop   = 1'b1;
                    w_next_state = arb.bus_gnt_i ? ST_I_DROP : ST_IDLE;
                end else if (arb.bus_gnt_i) begin
                    w_bus_drop   = 1'b1;
                    w_next_state = ST_I_WAIT;
                end
            end
            ST_I_WAIT: begin
                // A flush coinciding with the response simply discards it
                if (arb.bus_rvalid_i) begin
                    w_i_done     = ~arb.flush_i;
                    w_next_state = ST_IDLE;
                end else if (arb.flush_i) begin
                    w_next_state = ST_I_DROP;
                end
            end
            ST_I_DROP: begin
                if (arb.bus_rvalid_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_D_REQ: begin
                if (arb.bus_gnt_i) begin
                    w_bus_drop   = 1'b1;
                    w_next_state = ST_D_WAIT;
                end
            end
            ST_D_WAIT: begin
                if (arb.bus_rvalid_i) begin
                    w_d_done     = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_last_d    <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_op    <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_if_inst   <= '0;
            r_if_valid  <= 1'b0;
            r_d_rdata   <= '0;
            r_d_valid   <= 1'b0;
        end else begin
            r_if_valid <= w_i_done;
            r_d_valid  <= w_d_done;
            if (w_sel_d) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= arb.d_we_i;
                r_bus_op    <= arb.d_op_i;
                r_bus_addr  <= arb.d_addr_i;
                r_bus_wdata <= arb.d_wdata_i;
            end else if (w_sel_i) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= 1'b0;
                r_bus_op    <= FETCH_OP;
                r_bus_addr  <= arb.if_addr_i;
                r_bus_wdata <= '0;
            end else if (w_bus_drop) begin
                r_bus_req   <= 1'b0;
            end
            if (w_i_done) begin
                r_if_inst <= arb.bus_rdata_i;
                r_last_d  <= 1'b0;
            end
            if (w_d_done) begin
                r_d_rdata <= r_bus_we ? '0 : arb.bus_rdata_i;
                r_last_d  <= 1'b1;
            end
        end
    end

    assign arb.bus_req_o   = r_bus_req;
    assign arb.bus_we_o    = r_bus_we;
    assign arb.bus_op_o    = r_bus_op;
    assign arb.bus_addr_o  = r_bus_addr;
    assign arb.bus_wdata_o = r_bus_wdata;
    assign arb.if_inst_o   = r_if_inst;
    assign arb.if_valid_o  = r_if_valid;
    assign arb.d_rdata_o   = r_d_rdata;
    assign arb.d_valid_o   = r_d_valid;
    assign arb.stallreq_o  = (arb.d_req_i & ~r_d_valid) | (arb.if_req_i & ~r_if_valid)
                           | (r_state == ST_I_DROP);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction-fetch path (`pc_reg`/`if_id`) and the data path (`mem` stage). The core talks to one shared memory bus with a request/grant/response handshake. The block serialises the two requesters onto that bus and returns each response to its owner. While either requester waits, it raises a stall request to `pipe_ctrl`.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width (matches `` `ADDR_WIDTH ``)
- `DATA_WIDTH`, 32, data width (matches `` `DATA_WIDTH ``)

Ports:
- `clk_i`  in  1  clock, all state on rising edge
- `rst_i`  in  1  reset, asynchronous, active-low
- `if_req_i`  in  1  fetch request; held with `if_addr_i` stable until `if_valid_o`
- `if_addr_i`  in  ADDR_WIDTH  fetch address (pc)
- `if_inst_o`  out  DATA_WIDTH  fetched instruction, valid with `if_valid_o`
- `if_valid_o`  out  1  one-cycle fetch completion pulse
- `d_req_i`  in  1  data request; fields held stable until `d_valid_o`
- `d_we_i`  in  1  1 = store, 0 = load
- `d_op_i`  in  4  access size/sign code, passed through unchanged
- `d_addr_i`  in  ADDR_WIDTH  data address
- `d_wdata_i`  in  DATA_WIDTH  store data
- `d_rdata_o`  out  DATA_WIDTH  load data, valid with `d_valid_o`
- `d_valid_o`  out  1  one-cycle data completion pulse (stores too)
- `flush_i`  in  1  OR of `flush_jump` and `flush_interrupt`; cancels fetch only
- `stallreq_o`  out  1  stall request to `pipe_ctrl`
- `bus_req_o`  out  1  bus request, held until `bus_gnt_i`
- `bus_we_o`, `bus_op_o`[3:0], `bus_addr_o`, `bus_wdata_o`  out  —  registered copy of the winning request (fetch: `we`=0, `op`=word, `wdata`=0)
- `bus_gnt_i`  in  1  bus accepts the request this cycle
- `bus_rvalid_i`  in  1  response valid; exactly one per granted request
- `bus_rdata_i`  in  DATA_WIDTH  response data

## Operation
- States: IDLE, I_REQ, I_WAIT, I_DROP, D_REQ, D_WAIT.
- **IDLE, request selection:**
  - The block samples requests at the clock edge.
  - A requester whose `valid_o` is high this cycle is ignored, which gives a one-cycle bubble so stale held requests are not re-issued.
  - Only `d_req_i` → D_REQ.
  - Only `if_req_i` → I_REQ.
  - Both → the one not served last, tracked by a `last_d` flag (reset 0, i.e. data wins first). This alternation prevents starvation.
- **Request latch:** on entry to D_REQ/I_REQ, the bus fields are latched and `bus_req_o`=1.
- **X_REQ:** on `bus_gnt_i` → X_WAIT, deassert `bus_req_o`.
- **D_WAIT:** on `bus_rvalid_i`:
  - `d_rdata_o` ← `bus_rdata_i` (0 for stores), `d_valid_o`=1 next cycle.
  - Set `last_d`=1 → IDLE.
- **I_WAIT:** on `bus_rvalid_i`:
  - `if_inst_o` ← `bus_rdata_i`, `if_valid_o`=1 next cycle.
  - Set `last_d`=0 → IDLE.
- **Flush of a fetch:**
  - `flush_i` in I_REQ without `bus_gnt_i` → IDLE, with `bus_req_o` dropped.
  - In I_REQ with a same-cycle grant, or in I_WAIT → I_DROP.
  - I_DROP waits for `bus_rvalid_i` and discards the data (no `if_valid_o`) → IDLE.
  - `flush_i` has no effect in D_* states or in IDLE.
- **Stall:** `stallreq_o` = (`d_req_i` & ~`d_valid_o`) | (`if_req_i` & ~`if_valid_o`) | (state==I_DROP).

## Timing
- Reset values: state=IDLE, `last_d`=0, and all outputs 0 (`bus_req_o`, `bus_we_o`, `bus_op_o`, `bus_addr_o`, `bus_wdata_o`, `if_inst_o`, `if_valid_o`, `d_rdata_o`, `d_valid_o`). `stallreq_o` is then combinational from inputs.
- Reset mid-transaction returns to IDLE immediately. The bus must also be reset, since an outstanding response is not tracked.
- Minimum latency:
  - Request sampled at edge N.
  - `bus_req_o` high in cycle N+1.
  - `bus_gnt_i` in N+1, `bus_rvalid_i` in N+2.
  - `valid_o` in N+3.
  - Each added wait cycle on gnt/rvalid adds one cycle.
- At most one bus transaction is outstanding. `bus_gnt_i`/`bus_rvalid_i` seen in IDLE are ignored.
- `valid_o` pulses are exactly one cycle wide; `if_inst_o`/`d_rdata_o` hold their value until the next completion.

## Structure
- State encodings (3-bit) and the fetch op code constant go in `defines.v` next to the existing width defines.
- The block is a single module with no sub-module.
- `core_top` wires `stallreq_o` as a new input of `pipe_ctrl` and `flush_i` from `ctrl_flush_jump_o | flush_interrupt`.

## Test plan
- **Fetch only:** `if_req_i`=1, addr 0x100; bus gnt immediate, rvalid next cycle with 0x00500093 → `if_valid_o` at N+3, `if_inst_o`=0x00500093, `stallreq_o` high N..N+2.
- **Load with wait states:**
  - Stimulus: `d_req_i`, `d_we_i`=0, addr 0x2000; gnt delayed 2 cycles, rvalid 3 cycles later with 0xDEADBEEF.
  - Response: `d_valid_o` at N+7, `d_rdata_o`=0xDEADBEEF.
- **Simultaneous fetch and store after reset:** data served first (`bus_we_o`=1, `bus_wdata_o`=0x12345678), then fetch, then data again if still requested. Ordering alternates.
- **Flush before grant:** `flush_i` in I_REQ with no gnt → `bus_req_o` drops next cycle, no `if_valid_o`, state IDLE.
- **Flush in I_WAIT:** rvalid 0xAAAA5555 arrives in I_DROP → no `if_valid_o`, `if_inst_o` unchanged, `stallreq_o` high until rvalid.
- **Async reset in D_WAIT:** `rst_i` low mid-cycle → all outputs 0 immediately, state IDLE; next request is issued normally after release.
